ppu_pipe_ctrl: RTL and testbench

Issue and valid-tracking controller for the PPU arithmetic pipeline. It is the parametrised successor of the fixed 3-stage ADD/SUB/MUL/DIV sequencer.
- Accepts one operation per cycle through a valid/ready handshake.
- Holds the issue stage for multi-cycle DIV.
- Carries op code and tag down a configurable-depth delay line, so results emerge with matching op/tag.
- Adds flush, illegal-op detection and a busy indication.

---
 rtl/ppu_pipe_pkg.sv | 26 ++
 rtl/ppu_valid_delay_line.sv | 43 ++++
 rtl/ppu_pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_ppu_pipe_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pipe_pkg.sv
// Shared definitions for the PPU arithmetic pipeline: op codes, issue FSM states
// and the op legality helper.
package ppu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_F2P = 3'd4,
    OP_P2F = 3'd5
  } ppu_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DIV_BUSY = 1'b1
  } pipe_state_e;

  localparam int unsigned OP_LAST = 5;

  // Wide argument so callers of any op width can zero-extend into it.
  function automatic logic is_legal_op(input logic [31:0] op);
    return op <= 32'(OP_LAST);
  endfunction

endpackage

// File: rtl/ppu_valid_delay_line.sv
// Fixed-latency delay line carrying a valid bit plus payload; no stall, bubbles
// carry a zeroed payload, and a synchronous clear wipes every stage.
module ppu_valid_delay_line
  import ppu_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             exit_valid,
  output logic [WIDTH-1:0] exit_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else if (clear) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      valid_q[0] <= load;
      data_q[0]  <= load ? load_data : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  assign exit_valid = valid_q[DEPTH-1];
  assign exit_data  = data_q[DEPTH-1];
  assign any_valid  = |valid_q;

endmodule

// File: rtl/ppu_pipe_ctrl.sv
// Issue and valid-tracking controller for the PPU arithmetic pipeline: valid/ready
// issue, multi-cycle DIV hold, op/tag delay line, flush and illegal-op reporting.
module ppu_pipe_ctrl
  import ppu_pipe_pkg::*;
#(
  parameter int unsigned OP_SIZE    = 3,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned DIV_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic [OP_SIZE-1:0] op_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [OP_SIZE-1:0] op_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               err_o,
  output logic               busy_o
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam int unsigned PAY_W = OP_SIZE + TAG_W;
  localparam logic [OP_SIZE-1:0] DIV_CODE = OP_SIZE'(OP_DIV);
  localparam logic MULTI_DIV = (DIV_CYCLES > 1);

  pipe_state_e        state;
  logic [CNT_W-1:0]   cnt;
  logic [OP_SIZE-1:0] div_op;
  logic [TAG_W-1:0]   div_tag;
  logic               err_q;

  logic               accept;
  logic               legal;
  logic               is_div;
  logic               div_done;
  logic               ins_valid;
  logic [PAY_W-1:0]   ins_data;
  logic               line_valid;
  logic [PAY_W-1:0]   line_data;
  logic               line_busy;

  assign ready_o  = (state == ST_IDLE) && !flush_i;
  assign accept   = valid_i && ready_o;
  assign legal    = is_legal_op(32'(op_i));
  assign is_div   = (op_i == DIV_CODE);
  assign div_done = (state == ST_DIV_BUSY) && (cnt == CNT_W'(DIV_CYCLES - 1));

  // Stage 0 sees either the held DIV on its final cycle or a fresh legal op.
  always_comb begin
    ins_valid = 1'b0;
    ins_data  = '0;
    if (!flush_i) begin
      if (div_done) begin
        ins_valid = 1'b1;
        ins_data  = {div_op, div_tag};
      end else if (accept && legal && !(is_div && MULTI_DIV)) begin
        ins_valid = 1'b1;
        ins_data  = {op_i, tag_i};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      div_op  <= '0;
      div_tag <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      if (flush_i) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept && legal && is_div && MULTI_DIV) begin
              state   <= ST_DIV_BUSY;
              cnt     <= CNT_W'(1);
              div_op  <= op_i;
              div_tag <= tag_i;
            end
          end
          ST_DIV_BUSY: begin
            if (div_done) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  ppu_valid_delay_line #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH (PAY_W)
  ) u_delay_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (flush_i),
    .load       (ins_valid),
    .load_data  (ins_data),
    .exit_valid (line_valid),
    .exit_data  (line_data),
    .any_valid  (line_busy)
  );

  assign valid_o = line_valid;
  assign op_o    = line_data[PAY_W-1:TAG_W];
  assign tag_o   = line_data[TAG_W-1:0];
  assign err_o   = err_q;
  assign busy_o  = (state != ST_IDLE) || line_busy;

endmodule

// File: tb/tb_ppu_pipe_ctrl.sv
// Self-checking bench for ppu_pipe_ctrl: directed scenarios and random traffic
// compared cycle by cycle against a latency/queue reference model.
module tb_ppu_pipe_ctrl;

  localparam int OP_SIZE    = 3;
  localparam int TAG_W      = 4;
  localparam int PIPE_DEPTH = 3;
  localparam int DIV_CYCLES = 2;

  logic               clk;
  logic               rst_n;
  logic               valid_i;
  logic [OP_SIZE-1:0] op_i;
  logic [TAG_W-1:0]   tag_i;
  logic               flush_i;
  logic               ready_o;
  logic               valid_o;
  logic [OP_SIZE-1:0] op_o;
  logic [TAG_W-1:0]   tag_o;
  logic               err_o;
  logic               busy_o;

  ppu_pipe_ctrl #(
    .OP_SIZE    (OP_SIZE),
    .TAG_W      (TAG_W),
    .PIPE_DEPTH (PIPE_DEPTH),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .op_i    (op_i),
    .tag_i   (tag_i),
    .flush_i (flush_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .op_o    (op_o),
    .tag_o   (tag_o),
    .err_o   (err_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each accepted op becomes an entry with its exit cycle.
  typedef struct {
    int         acc;
    int         exit_cyc;
    logic [2:0] op;
    logic [3:0] tag;
  } entry_t;

  entry_t inflight[$];
  int     cyc;
  int     issue_free;
  bit     err_pending;
  int     checks;
  int     errors;

  logic       e_ready, e_valid, e_busy, e_err;
  logic [2:0] e_op;
  logic [3:0] e_tag;
  logic [8:0] stim[$];

  task automatic model_reset();
    inflight.delete();
    issue_free  = 0;
    err_pending = 1'b0;
  endtask

  task automatic model_eval();
    e_ready = !flush_i && (cyc >= issue_free);
    e_valid = 1'b0;
    e_busy  = 1'b0;
    e_op    = '0;
    e_tag   = '0;
    e_err   = err_pending;
    foreach (inflight[i]) begin
      if (inflight[i].exit_cyc == cyc) begin
        e_valid = 1'b1;
        e_op    = inflight[i].op;
        e_tag   = inflight[i].tag;
      end
      if (inflight[i].acc < cyc && cyc <= inflight[i].exit_cyc) e_busy = 1'b1;
    end
  endtask

  task automatic model_commit();
    bit     acc;
    entry_t e;
    acc = valid_i && e_ready;
    err_pending = acc && (op_i > 3'd5);
    if (acc && op_i <= 3'd5) begin
      e.acc      = cyc;
      e.op       = op_i;
      e.tag      = tag_i;
      e.exit_cyc = cyc + PIPE_DEPTH + ((op_i == 3'd3) ? DIV_CYCLES - 1 : 0);
      inflight.push_back(e);
      if (op_i == 3'd3) issue_free = cyc + DIV_CYCLES;
    end
    if (flush_i) begin
      inflight.delete();
      issue_free = cyc + 1;
    end
    while (inflight.size() > 0 && inflight[0].exit_cyc <= cyc) void'(inflight.pop_front());
  endtask

  task automatic drive(input logic fl, input logic v, input logic [2:0] op, input logic [3:0] tag);
    @(posedge clk);
    cyc++;
    #1;
    flush_i = fl;
    valid_i = v;
    op_i    = op;
    tag_i   = tag;
    @(negedge clk);
  endtask

  function automatic logic [8:0] mk(input logic fl, input logic v, input logic [2:0] op,
                                    input logic [3:0] tag);
    return {fl, v, op, tag};
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) stim.push_back(9'd0);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    valid_i = 1'b0;
    op_i    = '0;
    tag_i   = '0;
    flush_i = 1'b0;
    #12;
    checks++;
    if ({ready_o, valid_o, op_o, tag_o, busy_o, err_o} !== {1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b op=%0d tag=%0d busy=%b err=%b want rdy=1 vld=0 op=0 tag=0 busy=0 err=0",
               ready_o, valid_o, op_o, tag_o, busy_o, err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_directed();
    logic [8:0] w;
    stim.delete();
    stim.push_back(mk(0, 1, 3'd0, 4'd1));                       add_idle(6);
    stim.push_back(mk(0, 1, 3'd0, 4'd1));
    stim.push_back(mk(0, 1, 3'd1, 4'd2));
    stim.push_back(mk(0, 1, 3'd2, 4'd3));                       add_idle(6);
    stim.push_back(mk(0, 1, 3'd3, 4'd5));
    stim.push_back(mk(0, 1, 3'd2, 4'd6));
    stim.push_back(mk(0, 1, 3'd2, 4'd6));                       add_idle(6);
    stim.push_back(mk(0, 1, 3'd0, 4'd1));
    stim.push_back(mk(0, 1, 3'd3, 4'd2));
    stim.push_back(mk(1, 0, 3'd0, 4'd0));                       add_idle(6);
    stim.push_back(mk(0, 1, 3'd7, 4'd9));                       add_idle(4);
    stim.push_back(mk(0, 1, 3'd6, 4'd4));
    stim.push_back(mk(1, 1, 3'd7, 4'd8));                       add_idle(4);
    foreach (stim[i]) begin
      w = stim[i];
      drive(w[8], w[7], w[6:4], w[3:0]);
      model_eval();
      checks++;
      if (ready_o !== e_ready || valid_o !== e_valid || busy_o !== e_busy || err_o !== e_err ||
          (e_valid && (op_o !== e_op || tag_o !== e_tag))) begin
        errors++;
        $display("FAIL directed step=%0d got rdy=%b vld=%b op=%0d tag=%0d busy=%b err=%b want rdy=%b vld=%b op=%0d tag=%0d busy=%b err=%b",
                 i, ready_o, valid_o, op_o, tag_o, busy_o, err_o, e_ready, e_valid, e_op, e_tag, e_busy, e_err);
      end
      model_commit();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 48; i++) begin
      if (i < 40) drive(1'b0, 1'b1, 3'($urandom_range(0, 5)), 4'($urandom));
      else        drive(1'b0, 1'b0, 3'd0, 4'd0);
      model_eval();
      checks++;
      if (ready_o !== e_ready || valid_o !== e_valid || busy_o !== e_busy || err_o !== e_err ||
          (e_valid && (op_o !== e_op || tag_o !== e_tag))) begin
        errors++;
        $display("FAIL back_to_back i=%0d got rdy=%b vld=%b op=%0d tag=%0d busy=%b err=%b want rdy=%b vld=%b op=%0d tag=%0d busy=%b err=%b",
                 i, ready_o, valid_o, op_o, tag_o, busy_o, err_o, e_ready, e_valid, e_op, e_tag, e_busy, e_err);
      end
      model_commit();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 16) == 0, ($urandom % 4) != 0, 3'($urandom), 4'($urandom));
      model_eval();
      checks++;
      if (ready_o !== e_ready || valid_o !== e_valid || busy_o !== e_busy || err_o !== e_err ||
          (e_valid && (op_o !== e_op || tag_o !== e_tag))) begin
        errors++;
        $display("FAIL random i=%0d got rdy=%b vld=%b op=%0d tag=%0d busy=%b err=%b want rdy=%b vld=%b op=%0d tag=%0d busy=%b err=%b",
                 i, ready_o, valid_o, op_o, tag_o, busy_o, err_o, e_ready, e_valid, e_op, e_tag, e_busy, e_err);
      end
      model_commit();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 4'd0);
      model_eval();
      checks++;
      if (valid_o !== e_valid || busy_o !== e_busy || (e_valid && tag_o !== e_tag)) begin
        errors++;
        $display("FAIL random_drain i=%0d got vld=%b tag=%0d busy=%b want vld=%b tag=%0d busy=%b",
                 i, valid_o, tag_o, busy_o, e_valid, e_tag, e_busy);
      end
      model_commit();
    end
  endtask

  task automatic test_reset_mid_div();
    logic [8:0] w;
    stim.delete();
    stim.push_back(mk(0, 1, 3'd0, 4'd1));
    stim.push_back(mk(0, 1, 3'd3, 4'd2));
    stim.push_back(mk(0, 0, 3'd0, 4'd0));
    foreach (stim[i]) begin
      w = stim[i];
      drive(w[8], w[7], w[6:4], w[3:0]);
      model_eval();
      checks++;
      if (ready_o !== e_ready || valid_o !== e_valid || busy_o !== e_busy || err_o !== e_err) begin
        errors++;
        $display("FAIL pre_reset step=%0d got rdy=%b vld=%b busy=%b err=%b want rdy=%b vld=%b busy=%b err=%b",
                 i, ready_o, valid_o, busy_o, err_o, e_ready, e_valid, e_busy, e_err);
      end
      model_commit();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_o, valid_o, busy_o, err_o} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b vld=%b busy=%b err=%b want rdy=1 vld=0 busy=0 err=0",
               ready_o, valid_o, busy_o, err_o);
    end
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 4'd0);
      model_eval();
      checks++;
      if (ready_o !== e_ready || valid_o !== e_valid || busy_o !== e_busy || err_o !== e_err) begin
        errors++;
        $display("FAIL post_reset i=%0d got rdy=%b vld=%b busy=%b err=%b want rdy=%b vld=%b busy=%b err=%b",
                 i, ready_o, valid_o, busy_o, err_o, e_ready, e_valid, e_busy, e_err);
      end
      model_commit();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    model_reset();
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
